// File: rtl/operand_pair_feeder.sv
// Operand pair feeder: buffers two multi-block operands and replays them as one
// contiguous, lock-stepped burst of paired blocks into the big-number multiplier.
module operand_pair_feeder #(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM   = 4096
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [REGISTER_SIZE-1:0] n_data_in,
    input  logic                     n_valid_in,
    output logic                     n_ready_out,
    input  logic [REGISTER_SIZE-1:0] m_data_in,
    input  logic                     m_valid_in,
    output logic                     m_ready_out,
    input  logic                     mult_ready_in,
    output logic [REGISTER_SIZE-1:0] n_out,
    output logic [REGISTER_SIZE-1:0] m_out,
    output logic                     valid_out,
    output logic                     last_out,
    output logic                     busy_out
);
    localparam int NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
    localparam int AW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int CW = $clog2(NUM_BLOCKS + 1);
    localparam logic [CW-1:0] NUM_C = CW'(NUM_BLOCKS);
    localparam logic [CW-1:0] OMAX  = CW'(NUM_BLOCKS - 1);
    localparam logic [AW-1:0] AMAX  = AW'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {LOAD, WAIT_SINK, BURST} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            n_cnt_q, n_cnt_d, m_cnt_q, m_cnt_d, out_cnt_q, out_cnt_d;
    logic [AW-1:0]            rd_addr_q, rd_addr_d;
    logic                     rd_done_q, rd_done_d;
    logic                     v1_q, v1_d, v2_q, v2_d;
    logic                     valid_q, valid_d, last_q, last_d;
    logic [REGISTER_SIZE-1:0] n_out_q, n_out_d, m_out_q, m_out_d;
    logic                     rd_issue;
    logic                     n_fire, m_fire;

    logic [REGISTER_SIZE-1:0] n_mem [NUM_BLOCKS];
    logic [REGISTER_SIZE-1:0] m_mem [NUM_BLOCKS];
    logic [REGISTER_SIZE-1:0] n_rd1_q, n_rd2_q, m_rd1_q, m_rd2_q;

    // Readies are gated by reset so nothing is accepted while rst_in is low.
    assign n_ready_out = rst_in && (state_q == LOAD) && (n_cnt_q < NUM_C);
    assign m_ready_out = rst_in && (state_q == LOAD) && (m_cnt_q < NUM_C);
    assign n_fire      = n_valid_in && n_ready_out;
    assign m_fire      = m_valid_in && m_ready_out;
    assign busy_out    = rst_in && (state_q != LOAD);

    assign n_out     = n_out_q;
    assign m_out     = m_out_q;
    assign valid_out = valid_q;
    assign last_out  = last_q;

    always_comb begin
        state_d   = state_q;
        n_cnt_d   = n_cnt_q;
        m_cnt_d   = m_cnt_q;
        out_cnt_d = out_cnt_q;
        rd_addr_d = rd_addr_q;
        rd_done_d = rd_done_q;
        rd_issue  = 1'b0;

        if (v2_q) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end

        case (state_q)
            LOAD: begin
                if (n_fire) n_cnt_d = n_cnt_q + CW'(1);
                if (m_fire) m_cnt_d = m_cnt_q + CW'(1);
                if ((n_cnt_d == NUM_C) && (m_cnt_d == NUM_C)) state_d = WAIT_SINK;
            end
            WAIT_SINK: begin
                if (mult_ready_in) begin
                    state_d   = BURST;
                    rd_addr_d = '0;
                    rd_done_d = 1'b0;
                end
            end
            BURST: begin
                // Issue exactly NUM_BLOCKS reads; the address parks on the last block.
                rd_issue = !rd_done_q;
                if (rd_issue) begin
                    if (rd_addr_q == AMAX) rd_done_d = 1'b1;
                    else                   rd_addr_d = rd_addr_q + AW'(1);
                end
                if (valid_q && last_q) begin
                    state_d   = LOAD;
                    n_cnt_d   = '0;
                    m_cnt_d   = '0;
                    out_cnt_d = '0;
                end
            end
            default: state_d = LOAD;
        endcase

        // Valid tracks the two-cycle BRAM read plus the output register.
        v1_d    = rd_issue;
        v2_d    = v1_q;
        valid_d = v2_q;
        last_d  = v2_q && (out_cnt_q == OMAX);
        n_out_d = v2_q ? n_rd2_q : '0;
        m_out_d = v2_q ? m_rd2_q : '0;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= LOAD;
            n_cnt_q   <= '0;
            m_cnt_q   <= '0;
            out_cnt_q <= '0;
            rd_addr_q <= '0;
            rd_done_q <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            n_out_q   <= '0;
            m_out_q   <= '0;
        end else begin
            state_q   <= state_d;
            n_cnt_q   <= n_cnt_d;
            m_cnt_q   <= m_cnt_d;
            out_cnt_q <= out_cnt_d;
            rd_addr_q <= rd_addr_d;
            rd_done_q <= rd_done_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            n_out_q   <= n_out_d;
            m_out_q   <= m_out_d;
        end
    end

    // Dual-port read-first BRAM pair: write port fed by the loaders, read port
    // registered twice (array read + output register) for a 2-cycle latency.
    always_ff @(posedge clk_in) begin
        if (n_fire) n_mem[n_cnt_q[AW-1:0]] <= n_data_in;
        if (m_fire) m_mem[m_cnt_q[AW-1:0]] <= m_data_in;
        n_rd1_q <= n_mem[rd_addr_q];
        m_rd1_q <= m_mem[rd_addr_q];
        n_rd2_q <= n_rd1_q;
        m_rd2_q <= m_rd1_q;
    end
endmodule

// File: tb/tb_operand_pair_feeder.sv
// Bench for operand_pair_feeder: a 4-block instance for directed scenarios and a
// default 128-block instance for back-to-back random pairs, both scoreboarded.
module tb_operand_pair_feeder;
    localparam int S_NB = 4;
    localparam int B_NB = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Small instance (BITS_IN_NUM = 128)
    logic        s_rst, s_n_valid, s_m_valid, s_n_ready, s_m_ready, s_mult_ready;
    logic [31:0] s_n_data, s_m_data, s_n_out, s_m_out;
    logic        s_valid, s_last, s_busy;
    // Default instance (BITS_IN_NUM = 4096)
    logic        b_rst, b_n_valid, b_m_valid, b_n_ready, b_m_ready, b_mult_ready;
    logic [31:0] b_n_data, b_m_data, b_n_out, b_m_out;
    logic        b_valid, b_last, b_busy;

    logic [31:0] s_nblk [S_NB];
    logic [31:0] s_mblk [S_NB];
    logic [31:0] b_nblk [B_NB];
    logic [31:0] b_mblk [B_NB];
    logic [64:0] s_exp_q[$];
    logic [64:0] b_exp_q[$];
    int          s_run = 0;
    int          b_run = 0;
    bit          mon_en = 1'b0;

    operand_pair_feeder #(.REGISTER_SIZE(32), .BITS_IN_NUM(128)) dut_s (
        .clk_in(clk), .rst_in(s_rst),
        .n_data_in(s_n_data), .n_valid_in(s_n_valid), .n_ready_out(s_n_ready),
        .m_data_in(s_m_data), .m_valid_in(s_m_valid), .m_ready_out(s_m_ready),
        .mult_ready_in(s_mult_ready),
        .n_out(s_n_out), .m_out(s_m_out), .valid_out(s_valid), .last_out(s_last),
        .busy_out(s_busy)
    );

    operand_pair_feeder dut_b (
        .clk_in(clk), .rst_in(b_rst),
        .n_data_in(b_n_data), .n_valid_in(b_n_valid), .n_ready_out(b_n_ready),
        .m_data_in(b_m_data), .m_valid_in(b_m_valid), .m_ready_out(b_m_ready),
        .mult_ready_in(b_mult_ready),
        .n_out(b_n_out), .m_out(b_m_out), .valid_out(b_valid), .last_out(b_last),
        .busy_out(b_busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one block on the selected small-instance inputs and hold until accepted.
    task automatic s_drive(input bit do_n, input bit do_m, input int i);
        int t = 0;
        if (do_n) begin s_n_valid = 1'b1; s_n_data = s_nblk[i]; end
        if (do_m) begin
            s_m_valid = 1'b1; s_m_data = s_mblk[i];
            s_exp_q.push_back({(i == S_NB - 1), s_nblk[i], s_mblk[i]});
        end
        @(negedge clk);
        while (((do_n && !s_n_ready) || (do_m && !s_m_ready)) && t < 300) begin
            @(negedge clk); t++;
        end
        if (t >= 300) chk("s_drive timeout", 128'(t), 128'd0);
        @(posedge clk); #1;
        if (do_n) s_n_valid = 1'b0;
        if (do_m) s_m_valid = 1'b0;
    endtask

    task automatic b_drive(input int i);
        int t = 0;
        b_n_valid = 1'b1; b_n_data = b_nblk[i];
        b_m_valid = 1'b1; b_m_data = b_mblk[i];
        b_exp_q.push_back({(i == B_NB - 1), b_nblk[i], b_mblk[i]});
        @(negedge clk);
        while (!(b_n_ready && b_m_ready) && t < 1000) begin
            @(negedge clk); t++;
        end
        if (t >= 1000) chk("b_drive timeout", 128'(t), 128'd0);
        @(posedge clk); #1;
        b_n_valid = 1'b0;
        b_m_valid = 1'b0;
    endtask

    task automatic s_drain();
        int t = 0;
        while ((s_exp_q.size() != 0 || s_valid) && t < 600) begin
            @(posedge clk); #1; t++;
        end
        chk("s_drain remaining", 128'(s_exp_q.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    task automatic s_rand_pair();
        for (int i = 0; i < S_NB; i++) begin
            s_nblk[i] = $urandom();
            s_mblk[i] = $urandom();
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [64:0] e;
            if (s_valid) begin
                s_run++;
                if (s_exp_q.size() == 0) chk("s unexpected valid", 128'd1, 128'd0);
                else begin
                    e = s_exp_q.pop_front();
                    chk("s block", {63'd0, s_last, s_n_out, s_m_out}, {63'd0, e});
                end
            end else begin
                if (s_run != 0) begin
                    if (s_rst) chk("s burst length", 128'(s_run), 128'(S_NB));
                    s_run = 0;
                end
                chk("s idle outputs", {63'd0, s_last, s_n_out, s_m_out}, 128'd0);
            end
            if (b_valid) begin
                b_run++;
                if (b_exp_q.size() == 0) chk("b unexpected valid", 128'd1, 128'd0);
                else begin
                    e = b_exp_q.pop_front();
                    chk("b block", {63'd0, b_last, b_n_out, b_m_out}, {63'd0, e});
                end
            end else if (b_run != 0) begin
                chk("b burst length", 128'(b_run), 128'(B_NB));
                b_run = 0;
            end
        end
    end

    initial begin
        int lat;
        int t;
        s_rst = 1'b0; s_n_valid = 1'b0; s_m_valid = 1'b0; s_mult_ready = 1'b0;
        s_n_data = '0; s_m_data = '0;
        b_rst = 1'b0; b_n_valid = 1'b0; b_m_valid = 1'b0; b_mult_ready = 1'b1;
        b_n_data = '0; b_m_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset readies/busy", {125'd0, s_n_ready, s_m_ready, s_busy}, 128'd0);
        chk("reset outputs", {63'd0, s_valid, s_n_out, s_m_out}, 128'd0);
        s_rst = 1'b1; b_rst = 1'b1;
        mon_en = 1'b1;
        #1;
        chk("readies after release", {126'd0, s_n_ready, s_m_ready}, 128'd3);

        // Basic: concurrent load, latency from the decision edge
        s_nblk = '{32'h1, 32'h2, 32'h3, 32'h4};
        s_mblk = '{32'hA, 32'hB, 32'hC, 32'hD};
        s_mult_ready = 1'b1;
        for (int i = 0; i < S_NB; i++) s_drive(1'b1, 1'b1, i);
        chk("basic wait busy/readies", {125'd0, s_busy, s_n_ready, s_m_ready}, 128'd4);
        lat = 0;
        while (!s_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("basic first-valid latency", 128'(lat), 128'd4);
        s_drain();

        // Skewed: n first, idle, then m with random gaps
        s_rand_pair();
        for (int i = 0; i < S_NB; i++) s_drive(1'b1, 1'b0, i);
        chk("skew n_ready after n full", {126'd0, s_n_ready, s_m_ready}, 128'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("skew idle no valid", {127'd0, s_valid}, 128'd0);
        for (int i = 0; i < S_NB; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            s_drive(1'b0, 1'b1, i);
            chk("skew no early valid", {127'd0, s_valid}, 128'd0);
        end
        s_drain();

        // Backpressure: loaded pair held while the sink is busy
        s_rand_pair();
        s_mult_ready = 1'b0;
        for (int i = 0; i < S_NB; i++) s_drive(1'b1, 1'b1, i);
        s_n_valid = 1'b1; s_n_data = 32'hDEAD_BEEF;
        s_m_valid = 1'b1; s_m_data = 32'hBAAD_F00D;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("backpressure hold", {124'd0, s_busy, s_valid, s_n_ready, s_m_ready}, 128'd8);
        end
        @(posedge clk); #1;
        s_n_valid = 1'b0; s_m_valid = 1'b0;
        s_mult_ready = 1'b1;
        s_drain();

        // Reset while the second block is on the outputs
        s_rand_pair();
        for (int i = 0; i < S_NB; i++) s_drive(1'b1, 1'b1, i);
        t = 0;
        while (!s_valid && t < 20) begin
            @(posedge clk); #1; t++;
        end
        chk("midreset burst started", {127'd0, s_valid}, 128'd1);
        @(posedge clk); #1;
        s_rst = 1'b0;
        #1;
        chk("midreset readies/busy", {125'd0, s_n_ready, s_m_ready, s_busy}, 128'd0);
        @(posedge clk); #1;
        chk("midreset valid dropped", {127'd0, s_valid}, 128'd0);
        s_exp_q.delete();
        @(posedge clk); #1;
        s_rst = 1'b1;
        #1;
        chk("midreset readies after release", {126'd0, s_n_ready, s_m_ready}, 128'd3);
        s_rand_pair();
        for (int i = 0; i < S_NB; i++) s_drive(1'b1, 1'b1, i);
        s_drain();

        // Illegal valid: n held valid with all-ones after n is full
        s_rand_pair();
        for (int i = 0; i < S_NB; i++) s_drive(1'b1, 1'b0, i);
        s_n_valid = 1'b1; s_n_data = 32'hFFFF_FFFF;
        for (int i = 0; i < S_NB; i++) begin
            s_drive(1'b0, 1'b1, i);
            chk("illegal n_ready low", {127'd0, s_n_ready}, 128'd0);
        end
        @(posedge clk); #1;
        s_n_valid = 1'b0;
        s_drain();
        chk("illegal n_ready restored", {127'd0, s_n_ready}, 128'd1);

        // Back-to-back random pairs on the default-sized instance
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < B_NB; i++) begin
                b_nblk[i] = $urandom();
                b_mblk[i] = $urandom();
            end
            for (int i = 0; i < B_NB; i++) b_drive(i);
        end
        t = 0;
        while ((b_exp_q.size() != 0 || b_valid) && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        chk("b_drain remaining", 128'(b_exp_q.size()), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("b idle after bursts", {126'd0, b_valid, b_busy}, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_pair_feeder.md
Name: operand_pair_feeder

Overview:
- Upstream stage of the streaming big-number multiplier.
- Collects two BITS_IN_NUM-bit operands, n and m, each arriving independently as REGISTER_SIZE-bit blocks (least-significant block first) under valid/ready.
- Once both operands are complete and the multiplier reports ready, replays them as one unbroken, lock-stepped burst of NUM_BLOCKS paired blocks. The multiplier needs this contiguous valid stream for its load phase.

Parameters:
- REGISTER_SIZE, 32, block width in bits.
- BITS_IN_NUM, 4096, operand width in bits. Must be a multiple of REGISTER_SIZE.
- NUM_BLOCKS, BITS_IN_NUM/REGISTER_SIZE (=128), derived. Not overridable.

Ports:
- clk_in  input  1  single clock, all logic on rising edge.
- rst_in  input  1  synchronous reset, active-low.
- n_data_in  input  REGISTER_SIZE  n operand block.
- n_valid_in  input  1  n_data_in valid.
- n_ready_out  output  1  n block accepted when n_valid_in && n_ready_out.
- m_data_in  input  REGISTER_SIZE  m operand block.
- m_valid_in  input  1  m_data_in valid.
- m_ready_out  output  1  m block accepted when m_valid_in && m_ready_out.
- mult_ready_in  input  1  downstream multiplier idle and able to take a burst.
- n_out  output  REGISTER_SIZE  n block to multiplier.
- m_out  output  REGISTER_SIZE  m block to multiplier.
- valid_out  output  1  n_out/m_out valid. High for exactly NUM_BLOCKS consecutive cycles per burst.
- last_out  output  1  high with the final (index NUM_BLOCKS-1) block of a burst.
- busy_out  output  1  high in WAIT_SINK and BURST.

Behaviour:
- Storage: two NUM_BLOCKS-deep buffers (n, m) in the team's dual-port read-first BRAM with 2-cycle read latency. One port writes, the other reads.
- Counters: n_cnt, m_cnt in 0..NUM_BLOCKS. rd_addr in 0..NUM_BLOCKS-1. out_cnt counts emitted blocks.
- States: LOAD, WAIT_SINK, BURST.
- Reset (rst_in==0 at an edge):
  - State goes to LOAD; n_cnt, m_cnt, rd_addr, out_cnt go to 0.
  - Registered outputs go to 0: n_out, m_out, valid_out, last_out.
  - n_ready_out and m_ready_out are 0 while rst_in==0. busy_out is 0.
  - Reset mid-burst: valid_out is 0 from the next cycle on. The partial burst is abandoned and no further blocks are emitted. Buffer contents are don't-care.
- LOAD:
  - n_ready_out = (n_cnt < NUM_BLOCKS). m_ready_out = (m_cnt < NUM_BLOCKS). Both are combinational from state and counter.
  - An accepted n block is written at address n_cnt, then n_cnt increments. m is handled the same way, independently. Both operands may be accepted in the same cycle.
  - A valid while ready is low is ignored: no write, no count change.
  - Go to WAIT_SINK on the cycle in which both counts reach, or already equal, NUM_BLOCKS.
- WAIT_SINK:
  - Both readies are 0.
  - If mult_ready_in==1 at edge T: go to BURST with rd_addr=0.
- BURST:
  - rd_addr increments every cycle up to NUM_BLOCKS-1. Both buffers are read at the same address.
  - Output registers capture the BRAM data, so block i appears on n_out/m_out with valid_out=1 at cycle T+3+i.
  - valid_out stays high with no gaps for i = 0..NUM_BLOCKS-1. last_out=1 only at i = NUM_BLOCKS-1.
  - mult_ready_in is ignored once BURST starts.
  - On the edge after the last block is emitted: go to LOAD, clear n_cnt, m_cnt, out_cnt; valid_out and last_out return to 0.
- Outputs n_out and m_out are 0 whenever valid_out==0.
- Throughput: one block per cycle per operand input in LOAD.
- Minimum pair period: NUM_BLOCKS (load, if both streams are concurrent) + 1 + 3 + NUM_BLOCKS cycles.
- No arithmetic on data; blocks pass through bit-exact. Block order is preserved, least-significant first.

Test Plan (BITS_IN_NUM=128, REGISTER_SIZE=32, NUM_BLOCKS=4 unless noted):
- Basic: stream n=0x0000000400000003_0000000200000001 and m=0xD_C_B_A blocks concurrently, one block per cycle, with mult_ready_in=1 -> valid_out high for exactly 4 consecutive cycles, (n_out,m_out) = (1,A),(2,B),(3,C),(4,D), last_out on the 4th only, first valid exactly 3 cycles after the WAIT_SINK->BURST decision edge.
- Skewed inputs: send n fully, then idle 10 cycles, then send m with random valid gaps -> n_ready_out=0 after the 4th n block; the burst starts only after the 4th m block; output matches the inputs.
- Backpressure: both operands loaded, mult_ready_in=0 for 20 cycles -> busy_out=1, no valid_out, both readies 0, extra input valids dropped; raise mult_ready_in -> the correct burst follows.
- Reset mid-burst: drive rst_in=0 while the 2nd block is on the outputs -> valid_out=0 on the next cycle, readies 0 during reset, then 1 after release; a fresh pair loads and bursts correctly.
- Back-to-back pairs, default params (NUM_BLOCKS=128): two random 4096-bit pairs -> two 128-cycle contiguous bursts, bit-exact with the inputs, one last_out per burst.
- Illegal valid: n_valid_in held high after n is full, with data 0xFFFFFFFF -> ignored; the burst carries the original blocks and n_cnt does not overflow.
